pulse_measure: RTL and testbench

PULSE_MEASURE -- requirements
Module: pulse_measure

---
 rtl/pulse_measure.sv | 200 ++++++++++++++++++++
 tb/tb_pulse_measure.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_measure.sv
// rtl/pulse_measure.sv - threshold-crossing pulse period/high-time/extrema measurement
module pulse_measure #(
    parameter int CNT_W = 24,
    parameter int HYST  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       sample,
    input  logic             sample_en,
    input  logic [7:0]       threshold,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [7:0]       peak,
    output logic [7:0]       trough,
    output logic             meas_valid,
    output logic             no_signal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hold_high;
    logic [7:0]       r_run_peak;
    logic [7:0]       r_run_trough;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic [7:0]       r_peak;
    logic [7:0]       r_trough;
    logic             r_meas_valid;
    logic             r_no_signal;

    logic [8:0]       w_sum;
    logic [7:0]       w_th_hi;
    logic [7:0]       w_th_lo;
    logic             w_level_nx;
    logic             w_rise;
    logic             w_fall;
    logic             w_cnt_max;
    logic             w_capture;
    logic             w_timeout;
    logic             w_restart;
    logic             w_cnt_inc;
    logic             w_hold_load;
    logic             w_ext_upd;

    // Saturating hysteresis band; a 9-bit sum and a 9-bit compare keep both edges from wrapping
    assign w_sum   = {1'b0, threshold} + 9'(HYST);
    assign w_th_hi = (w_sum > 9'd255) ? 8'hFF : w_sum[7:0];
    assign w_th_lo = ({1'b0, threshold} >= 9'(HYST)) ? (threshold - 8'(HYST)) : 8'h00;

    // Level the current enabled sample would leave behind, and the crossings it causes
    always_comb begin
        w_level_nx = r_level;
        if (sample >= w_th_hi) begin
            w_level_nx = 1'b1;
        end else if (sample <= w_th_lo) begin
            w_level_nx = 1'b0;
        end
    end

    assign w_rise    = sample_en & ~r_level & w_level_nx;
    assign w_fall    = sample_en & r_level & ~w_level_nx;
    assign w_cnt_max = (r_cnt == {CNT_W{1'b1}});

    // Next-state and datapath control; nothing moves unless the sample is enabled
    always_comb begin
        w_state_nx  = r_state;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_restart   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_hold_load = 1'b0;
        w_ext_upd   = 1'b0;
        if (sample_en) begin
            case (r_state)
                IDLE: begin
                    if (!w_level_nx) begin
                        w_state_nx = ARM;
                    end
                end
                ARM: begin
                    if (w_rise) begin
                        w_state_nx = HIGH;
                        w_restart  = 1'b1;
                    end
                end
                HIGH: begin
                    if (w_cnt_max) begin
                        w_state_nx = IDLE;
                        w_timeout  = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                        w_ext_upd = 1'b1;
                        if (w_fall) begin
                            w_hold_load = 1'b1;
                            w_state_nx  = LOW;
                        end
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        w_state_nx = HIGH;
                        w_capture  = 1'b1;
                        w_restart  = 1'b1;
                    end else if (w_cnt_max) begin
                        w_state_nx = IDLE;
                        w_timeout  = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                        w_ext_upd = 1'b1;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Hysteresis level, sample counter, running extrema and held high time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level      <= 1'b0;
            r_cnt        <= '0;
            r_hold_high  <= '0;
            r_run_peak   <= 8'h00;
            r_run_trough <= 8'hFF;
        end else if (sample_en) begin
            r_level <= w_level_nx;
            if (w_restart) begin
                r_cnt        <= {{(CNT_W-1){1'b0}}, 1'b1};
                r_run_peak   <= sample;
                r_run_trough <= sample;
            end else begin
                if (w_cnt_inc) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_ext_upd) begin
                    if (sample > r_run_peak) begin
                        r_run_peak <= sample;
                    end
                    if (sample < r_run_trough) begin
                        r_run_trough <= sample;
                    end
                end
            end
            if (w_hold_load) begin
                r_hold_high <= r_cnt;
            end
        end
    end

    // Registered results, one-cycle strobe and sticky no-signal flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period     <= '0;
            r_high_time  <= '0;
            r_peak       <= 8'h00;
            r_trough     <= 8'hFF;
            r_meas_valid <= 1'b0;
            r_no_signal  <= 1'b0;
        end else begin
            r_meas_valid <= w_capture;
            if (w_capture) begin
                r_period    <= r_cnt;
                r_high_time <= r_hold_high;
                r_peak      <= r_run_peak;
                r_trough    <= r_run_trough;
                r_no_signal <= 1'b0;
            end else if (w_timeout) begin
                r_no_signal <= 1'b1;
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign peak       = r_peak;
    assign trough     = r_trough;
    assign meas_valid = r_meas_valid;
    assign no_signal  = r_no_signal;

endmodule

// File: tb/tb_pulse_measure.sv
// tb/tb_pulse_measure.sv - directed self-checking bench for pulse_measure
module tb_pulse_measure;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sample;
    logic        sample_en;
    logic [7:0]  threshold;
    logic [23:0] period, high_time;
    logic [7:0]  peak, trough;
    logic        meas_valid, no_signal;
    logic [7:0]  period8, high_time8;
    logic [7:0]  peak8, trough8;
    logic        mv8, ns8;

    int n_pass = 0;
    int n_total = 0;
    int strobes = 0;
    int strobes8 = 0;
    int n_wide = 0;
    int cyc = 0;
    int last_cyc = 0;
    int spacing = 0;
    logic mv_prev = 1'b0;

    always #5 clk = ~clk;

    pulse_measure dut (
        .clk(clk), .reset(reset), .sample(sample), .sample_en(sample_en),
        .threshold(threshold), .period(period), .high_time(high_time),
        .peak(peak), .trough(trough), .meas_valid(meas_valid), .no_signal(no_signal)
    );

    pulse_measure #(.CNT_W(8), .HYST(4)) dut8 (
        .clk(clk), .reset(reset), .sample(sample), .sample_en(sample_en),
        .threshold(threshold), .period(period8), .high_time(high_time8),
        .peak(peak8), .trough(trough8), .meas_valid(mv8), .no_signal(ns8)
    );

    // present one sample for one clock, then observe at the falling edge
    task automatic send(input logic [7:0] s, input logic en);
        sample = s;
        sample_en = en;
        @(negedge clk);
        cyc++;
        if (meas_valid) begin
            if (mv_prev) n_wide++;
            strobes++;
            spacing = cyc - last_cyc;
            last_cyc = cyc;
        end
        mv_prev = meas_valid;
        if (mv8) strobes8++;
    endtask

    task automatic burst(input logic [7:0] s, input int n, input logic sparse);
        for (int i = 0; i < n; i++) begin
            send(s, 1'b1);
            if (sparse) begin
                send(8'd0, 1'b0);
                send(8'd0, 1'b0);
            end
        end
    endtask

    task automatic do_reset(input logic [7:0] th);
        threshold = th;
        sample = 8'd0;
        sample_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        strobes = 0;
        strobes8 = 0;
        n_wide = 0;
        mv_prev = 1'b0;
    endtask

    task automatic square(input logic sparse);
        for (int r = 0; r < 3; r++) begin
            burst(8'd200, 10, sparse);
            burst(8'd50, 10, sparse);
        end
        burst(8'd200, 1, sparse);
    endtask

    task automatic test_reset;
        threshold = 8'd128;
        sample = 8'd0;
        sample_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_total++; if (period !== 24'd0) $display("FAIL rst_period got %0d want 0", period); else n_pass++;
        n_total++; if (high_time !== 24'd0) $display("FAIL rst_high got %0d want 0", high_time); else n_pass++;
        n_total++; if (peak !== 8'd0) $display("FAIL rst_peak got %0d want 0", peak); else n_pass++;
        n_total++; if (trough !== 8'd255) $display("FAIL rst_trough got %0d want 255", trough); else n_pass++;
        n_total++; if (meas_valid !== 1'b0) $display("FAIL rst_mv got %b want 0", meas_valid); else n_pass++;
        n_total++; if (no_signal !== 1'b0) $display("FAIL rst_ns got %b want 0", no_signal); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_square;
        do_reset(8'd128);
        square(1'b0);
        n_total++; if (strobes !== 2) $display("FAIL sq_strobes got %0d want 2", strobes); else n_pass++;
        n_total++; if (meas_valid !== 1'b1) $display("FAIL sq_mv got %b want 1", meas_valid); else n_pass++;
        n_total++; if (period !== 24'd20) $display("FAIL sq_period got %0d want 20", period); else n_pass++;
        n_total++; if (high_time !== 24'd10) $display("FAIL sq_high got %0d want 10", high_time); else n_pass++;
        n_total++; if (peak !== 8'd200) $display("FAIL sq_peak got %0d want 200", peak); else n_pass++;
        n_total++; if (trough !== 8'd50) $display("FAIL sq_trough got %0d want 50", trough); else n_pass++;
        burst(8'd200, 3, 1'b0);
        n_total++; if (meas_valid !== 1'b0) $display("FAIL sq_mv_drop got %b want 0", meas_valid); else n_pass++;
        n_total++; if (n_wide !== 0) $display("FAIL sq_wide got %0d want 0", n_wide); else n_pass++;
        n_total++; if (period !== 24'd20) $display("FAIL sq_hold got %0d want 20", period); else n_pass++;
    endtask

    task automatic test_sparse;
        do_reset(8'd128);
        square(1'b1);
        n_total++; if (strobes !== 2) $display("FAIL sp_strobes got %0d want 2", strobes); else n_pass++;
        n_total++; if (spacing !== 60) $display("FAIL sp_spacing got %0d want 60", spacing); else n_pass++;
        n_total++; if (period !== 24'd20) $display("FAIL sp_period got %0d want 20", period); else n_pass++;
        n_total++; if (high_time !== 24'd10) $display("FAIL sp_high got %0d want 10", high_time); else n_pass++;
        n_total++; if (peak !== 8'd200) $display("FAIL sp_peak got %0d want 200", peak); else n_pass++;
        n_total++; if (trough !== 8'd50) $display("FAIL sp_trough got %0d want 50", trough); else n_pass++;
        n_total++; if (n_wide !== 0) $display("FAIL sp_wide got %0d want 0", n_wide); else n_pass++;
    endtask

    task automatic noise;
        send(8'd130, 1'b1);
        send(8'd126, 1'b1);
        send(8'd131, 1'b1);
        send(8'd125, 1'b1);
        send(8'd130, 1'b1);
    endtask

    task automatic test_hysteresis;
        do_reset(8'd128);
        burst(8'd50, 10, 1'b0);
        burst(8'd200, 10, 1'b0);
        burst(8'd50, 10, 1'b0);
        burst(8'd200, 5, 1'b0);
        noise();
        burst(8'd50, 5, 1'b0);
        noise();
        burst(8'd200, 1, 1'b0);
        n_total++; if (strobes !== 2) $display("FAIL hy_strobes got %0d want 2", strobes); else n_pass++;
        n_total++; if (period !== 24'd20) $display("FAIL hy_period got %0d want 20", period); else n_pass++;
        n_total++; if (high_time !== 24'd10) $display("FAIL hy_high got %0d want 10", high_time); else n_pass++;
        n_total++; if (peak !== 8'd200) $display("FAIL hy_peak got %0d want 200", peak); else n_pass++;
        n_total++; if (trough !== 8'd50) $display("FAIL hy_trough got %0d want 50", trough); else n_pass++;
    endtask

    task automatic test_timeout;
        do_reset(8'd128);
        burst(8'd50, 10, 1'b0);
        burst(8'd200, 10, 1'b0);
        burst(8'd50, 10, 1'b0);
        burst(8'd200, 1, 1'b0);
        n_total++; if (strobes8 !== 1) $display("FAIL to_first got %0d want 1", strobes8); else n_pass++;
        burst(8'd200, 254, 1'b0);
        n_total++; if (ns8 !== 1'b0) $display("FAIL to_early got %b want 0", ns8); else n_pass++;
        burst(8'd200, 1, 1'b0);
        n_total++; if (ns8 !== 1'b1) $display("FAIL to_ns got %b want 1", ns8); else n_pass++;
        n_total++; if (dut8.r_state !== 2'd0) $display("FAIL to_idle got %0d want 0", dut8.r_state); else n_pass++;
        n_total++; if (strobes8 !== 1) $display("FAIL to_nostrobe got %0d want 1", strobes8); else n_pass++;
        n_total++; if (period8 !== 8'd20) $display("FAIL to_hold got %0d want 20", period8); else n_pass++;
        burst(8'd200, 5, 1'b0);
        burst(8'd50, 10, 1'b0);
        burst(8'd200, 10, 1'b0);
        burst(8'd50, 10, 1'b0);
        n_total++; if (ns8 !== 1'b1) $display("FAIL to_sticky got %b want 1", ns8); else n_pass++;
        burst(8'd200, 1, 1'b0);
        n_total++; if (mv8 !== 1'b1) $display("FAIL to_mv got %b want 1", mv8); else n_pass++;
        n_total++; if (ns8 !== 1'b0) $display("FAIL to_clear got %b want 0", ns8); else n_pass++;
        n_total++; if (strobes8 !== 2) $display("FAIL to_strobes got %0d want 2", strobes8); else n_pass++;
    endtask

    task automatic test_boundary;
        do_reset(8'd254);
        burst(8'd0, 3, 1'b0);
        burst(8'd254, 2, 1'b0);
        burst(8'd255, 1, 1'b0);
        burst(8'd0, 2, 1'b0);
        burst(8'd255, 1, 1'b0);
        n_total++; if (strobes !== 1) $display("FAIL b254_strobes got %0d want 1", strobes); else n_pass++;
        n_total++; if (period !== 24'd3) $display("FAIL b254_period got %0d want 3", period); else n_pass++;
        n_total++; if (high_time !== 24'd1) $display("FAIL b254_high got %0d want 1", high_time); else n_pass++;
        n_total++; if (peak !== 8'd255) $display("FAIL b254_peak got %0d want 255", peak); else n_pass++;
        n_total++; if (trough !== 8'd0) $display("FAIL b254_trough got %0d want 0", trough); else n_pass++;
        do_reset(8'd2);
        burst(8'd0, 1, 1'b0);
        burst(8'd10, 2, 1'b0);
        burst(8'd1, 2, 1'b0);
        burst(8'd0, 2, 1'b0);
        burst(8'd10, 1, 1'b0);
        n_total++; if (strobes !== 1) $display("FAIL b2_strobes got %0d want 1", strobes); else n_pass++;
        n_total++; if (period !== 24'd6) $display("FAIL b2_period got %0d want 6", period); else n_pass++;
        n_total++; if (high_time !== 24'd4) $display("FAIL b2_high got %0d want 4", high_time); else n_pass++;
        n_total++; if (peak !== 8'd10) $display("FAIL b2_peak got %0d want 10", peak); else n_pass++;
        n_total++; if (trough !== 8'd0) $display("FAIL b2_trough got %0d want 0", trough); else n_pass++;
    endtask

    task automatic test_async_reset;
        do_reset(8'd128);
        square(1'b0);
        burst(8'd200, 3, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_total++; if (period !== 24'd0) $display("FAIL ar_period got %0d want 0", period); else n_pass++;
        n_total++; if (high_time !== 24'd0) $display("FAIL ar_high got %0d want 0", high_time); else n_pass++;
        n_total++; if (peak !== 8'd0) $display("FAIL ar_peak got %0d want 0", peak); else n_pass++;
        n_total++; if (trough !== 8'd255) $display("FAIL ar_trough got %0d want 255", trough); else n_pass++;
        n_total++; if (dut.r_state !== 2'd0) $display("FAIL ar_state got %0d want 0", dut.r_state); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        strobes = 0;
        mv_prev = 1'b0;
        burst(8'd200, 3, 1'b0);
        burst(8'd50, 10, 1'b0);
        burst(8'd200, 10, 1'b0);
        burst(8'd50, 10, 1'b0);
        n_total++; if (strobes !== 0) $display("FAIL ar_early got %0d want 0", strobes); else n_pass++;
        burst(8'd200, 1, 1'b0);
        n_total++; if (strobes !== 1) $display("FAIL ar_strobe got %0d want 1", strobes); else n_pass++;
        n_total++; if (period !== 24'd20) $display("FAIL ar_period2 got %0d want 20", period); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_square();
        test_sparse();
        test_hysteresis();
        test_timeout();
        test_boundary();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
